// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - dual-mode parametrised video timing generator with registered sync/de/coordinates
module vga_timing_gen #(
    parameter int   CNT_W        = 11,
    parameter logic HS_POL       = 1'b1,
    parameter logic VS_POL       = 1'b1,
    parameter int   M0_H_SYNC    = 80,
    parameter int   M0_H_BACK    = 160,
    parameter int   M0_H_DISPLAY = 800,
    parameter int   M0_H_FRONT   = 16,
    parameter int   M0_V_SYNC    = 3,
    parameter int   M0_V_BACK    = 21,
    parameter int   M0_V_DISPLAY = 600,
    parameter int   M0_V_FRONT   = 1,
    parameter int   M1_H_SYNC    = 96,
    parameter int   M1_H_BACK    = 48,
    parameter int   M1_H_DISPLAY = 640,
    parameter int   M1_H_FRONT   = 16,
    parameter int   M1_V_SYNC    = 2,
    parameter int   M1_V_BACK    = 33,
    parameter int   M1_V_DISPLAY = 480,
    parameter int   M1_V_FRONT   = 10
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             mode,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             active_mode
);

    // Per-mode segment boundaries, precomputed in counter width.
    // *_BE is the first visible count (sync + back porch), *_L the last count of a line/frame.
    localparam logic [CNT_W-1:0] M0_HS = CNT_W'(M0_H_SYNC);
    localparam logic [CNT_W-1:0] M0_HBE = CNT_W'(M0_H_SYNC + M0_H_BACK);
    localparam logic [CNT_W-1:0] M0_HD = CNT_W'(M0_H_DISPLAY);
    localparam logic [CNT_W-1:0] M0_HL = CNT_W'(M0_H_SYNC + M0_H_BACK + M0_H_DISPLAY + M0_H_FRONT - 1);
    localparam logic [CNT_W-1:0] M0_VS = CNT_W'(M0_V_SYNC);
    localparam logic [CNT_W-1:0] M0_VBE = CNT_W'(M0_V_SYNC + M0_V_BACK);
    localparam logic [CNT_W-1:0] M0_VD = CNT_W'(M0_V_DISPLAY);
    localparam logic [CNT_W-1:0] M0_VL = CNT_W'(M0_V_SYNC + M0_V_BACK + M0_V_DISPLAY + M0_V_FRONT - 1);
    localparam logic [CNT_W-1:0] M1_HS = CNT_W'(M1_H_SYNC);
    localparam logic [CNT_W-1:0] M1_HBE = CNT_W'(M1_H_SYNC + M1_H_BACK);
    localparam logic [CNT_W-1:0] M1_HD = CNT_W'(M1_H_DISPLAY);
    localparam logic [CNT_W-1:0] M1_HL = CNT_W'(M1_H_SYNC + M1_H_BACK + M1_H_DISPLAY + M1_H_FRONT - 1);
    localparam logic [CNT_W-1:0] M1_VS = CNT_W'(M1_V_SYNC);
    localparam logic [CNT_W-1:0] M1_VBE = CNT_W'(M1_V_SYNC + M1_V_BACK);
    localparam logic [CNT_W-1:0] M1_VD = CNT_W'(M1_V_DISPLAY);
    localparam logic [CNT_W-1:0] M1_VL = CNT_W'(M1_V_SYNC + M1_V_BACK + M1_V_DISPLAY + M1_V_FRONT - 1);

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;

    logic [CNT_W-1:0] h_sync_end;
    logic [CNT_W-1:0] h_vis_start;
    logic [CNT_W-1:0] h_disp_len;
    logic [CNT_W-1:0] h_last;
    logic [CNT_W-1:0] v_sync_end;
    logic [CNT_W-1:0] v_vis_start;
    logic [CNT_W-1:0] v_disp_len;
    logic [CNT_W-1:0] v_last;

    logic [CNT_W-1:0] h_off;
    logic [CNT_W-1:0] v_off;
    logic             h_vis;
    logic             v_vis;

    // Select the timing set of the mode currently in effect.
    always_comb begin
        h_sync_end  = M0_HS;
        h_vis_start = M0_HBE;
        h_disp_len  = M0_HD;
        h_last      = M0_HL;
        v_sync_end  = M0_VS;
        v_vis_start = M0_VBE;
        v_disp_len  = M0_VD;
        v_last      = M0_VL;
        if (active_mode) begin
            h_sync_end  = M1_HS;
            h_vis_start = M1_HBE;
            h_disp_len  = M1_HD;
            h_last      = M1_HL;
            v_sync_end  = M1_VS;
            v_vis_start = M1_VBE;
            v_disp_len  = M1_VD;
            v_last      = M1_VL;
        end
    end

    // Visible-window decode; the offset test avoids computing an end bound that could overflow CNT_W.
    always_comb begin
        h_off = hcount - h_vis_start;
        v_off = vcount - v_vis_start;
        h_vis = (hcount >= h_vis_start) && (h_off < h_disp_len);
        v_vis = (vcount >= v_vis_start) && (v_off < v_disp_len);
    end

    // Raster counters; the requested mode is adopted only at reset or a full-frame wrap.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            active_mode <= mode;
        end else if (ce) begin
            if (hcount == h_last) begin
                hcount <= '0;
                if (vcount == v_last) begin
                    vcount      <= '0;
                    active_mode <= mode;
                end else begin
                    vcount <= vcount + 1'b1;
                end
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    // Registered outputs decoded from the pre-increment counter state, all with one cycle of latency.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hsync       <= (hcount < h_sync_end) ? HS_POL : ~HS_POL;
            vsync       <= (vcount < v_sync_end) ? VS_POL : ~VS_POL;
            de          <= h_vis && v_vis;
            pixel_x     <= (h_vis && v_vis) ? h_off : '0;
            pixel_y     <= (h_vis && v_vis) ? v_off : '0;
            line_start  <= (hcount == '0);
            frame_start <= (hcount == '0) && (vcount == '0);
        end
    end

endmodule
